// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   // Controller states; encoding 2'd3 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int         CNT_W   = 4;
   localparam logic [1:0] BR_NONE = 2'b00;

   // Any nonzero branch code means the branch resolved as taken.
   function automatic logic br_taken(input logic [1:0] br);
      return (br != BR_NONE);
   endfunction

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Load-use comparator: flags a load in ID/EX whose destination is read by the
// instruction in IF/ID. Register 0 is hardwired and never creates a hazard.
module hazard_loaduse_cmp #(
   parameter int REG_AW = 5
) (
   input  logic              memread_i,
   input  logic [REG_AW-1:0] idex_rt_i,
   input  logic [REG_AW-1:0] ifid_rs_i,
   input  logic [REG_AW-1:0] ifid_rt_i,
   input  logic              uses_rt_i,
   output logic              hit_o
);

   logic rt_nonzero_s;
   logic rs_match_s;
   logic rt_match_s;

   assign rt_nonzero_s = (idex_rt_i != {REG_AW{1'b0}});
   assign rs_match_s   = (idex_rt_i == ifid_rs_i);
   assign rt_match_s   = uses_rt_i & (idex_rt_i == ifid_rt_i);
   assign hit_o        = memread_i & rt_nonzero_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multiply-latency holds, load-use stalls and
// taken-branch fetch flushes. Outputs are combinational from state and inputs.
// Optional feature: define HAZARD_STATS_EN to add saturating StallCnt/FlushCnt.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int MUL_LAT  = 3,
   parameter int BR_SLOTS = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [1:0]        Branch,
   input  logic              IDEX_MemRead,
   input  logic [REG_AW-1:0] IDEX_Rt,
   input  logic [REG_AW-1:0] IFID_Rs,
   input  logic [REG_AW-1:0] IFID_Rt,
   input  logic              IFID_UsesRt,
   input  logic              MulStart,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              IDEXWrite,
   output logic              IFIDFlush,
   output logic              IDEXFlush,
   output logic              EXMEMFlush,
`ifdef HAZARD_STATS_EN
   output logic [31:0]       StallCnt,
   output logic [31:0]       FlushCnt,
`endif
   output logic              Busy
);

   // Counter preloads; the MUL preload doubles as the number of MUL cycles
   // that follow the initial hold cycle spent in IDLE.
   localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] BR_LOAD  = (BR_SLOTS > 1) ? CNT_W'(BR_SLOTS - 2) : {CNT_W{1'b0}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_s;
   logic             pc_wr_s, ifid_wr_s, idex_wr_s;
   logic             ifid_fl_s, idex_fl_s, exmem_fl_s, busy_s;

   hazard_loaduse_cmp #(.REG_AW(REG_AW)) u_cmp (
      .memread_i (IDEX_MemRead),
      .idex_rt_i (IDEX_Rt),
      .ifid_rs_i (IFID_Rs),
      .ifid_rt_i (IFID_Rt),
      .uses_rt_i (IFID_UsesRt),
      .hit_o     (hit_s)
   );

   // State and countdown register; reset aborts any hold or flush in progress.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and raw output decode, idle pattern assigned first.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_wr_s    = 1'b1;
      ifid_wr_s  = 1'b1;
      idex_wr_s  = 1'b1;
      ifid_fl_s  = 1'b0;
      idex_fl_s  = 1'b0;
      exmem_fl_s = 1'b0;
      busy_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((MUL_LAT > 1) && MulStart) begin
               pc_wr_s    = 1'b0;
               ifid_wr_s  = 1'b0;
               idex_wr_s  = 1'b0;
               exmem_fl_s = 1'b1;
               cnt_d      = MUL_LOAD;
               if (MUL_LAT > 2) begin
                  state_d = MUL;
               end else begin
                  state_d = IDLE;
               end
            end else if (hit_s) begin
               pc_wr_s   = 1'b0;
               ifid_wr_s = 1'b0;
               idex_fl_s = 1'b1;
            end else if (br_taken(Branch)) begin
               ifid_fl_s = 1'b1;
               if (BR_SLOTS > 1) begin
                  cnt_d   = BR_LOAD;
                  state_d = FLUSH;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         MUL: begin
            pc_wr_s    = 1'b0;
            ifid_wr_s  = 1'b0;
            idex_wr_s  = 1'b0;
            exmem_fl_s = 1'b1;
            busy_s     = 1'b1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         FLUSH: begin
            ifid_fl_s = 1'b1;
            busy_s    = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // While Reset is held the pipeline sees the idle pattern.
   always_comb begin
      if (Reset) begin
         PCWrite    = 1'b1;
         IFIDWrite  = 1'b1;
         IDEXWrite  = 1'b1;
         IFIDFlush  = 1'b0;
         IDEXFlush  = 1'b0;
         EXMEMFlush = 1'b0;
         Busy       = 1'b0;
      end else begin
         PCWrite    = pc_wr_s;
         IFIDWrite  = ifid_wr_s;
         IDEXWrite  = idex_wr_s;
         IFIDFlush  = ifid_fl_s;
         IDEXFlush  = idex_fl_s;
         EXMEMFlush = exmem_fl_s;
         Busy       = busy_s;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating event counters for stalled-PC and IF/ID-flush cycles.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (IFIDFlush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`endif

endmodule
